// File: rtl/hanoi_move_gen.sv
// hanoi_move_gen: streams the optimal Tower-of-Hanoi move list for NUM_DISKS
// disks from peg 0 to peg dst_peg, one move per accepted valid/ready handshake.
// Move m moves disk ctz(m); disk 0 always steps cyclically in a fixed
// direction, and every other disk has exactly one legal target.
module hanoi_move_gen #(
    parameter int NUM_DISKS = 3,
    parameter int DISK_W    = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [1:0]           dst_peg,
    input  logic                 abort,
    input  logic                 move_ready,
    output logic                 move_valid,
    output logic [1:0]           from_peg,
    output logic [1:0]           to_peg,
    output logic [DISK_W-1:0]    disk,
    output logic [NUM_DISKS-1:0] move_idx,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    typedef enum logic [1:0] {IDLE, PRESENT, FINISH} state_t;

    // m carries one spare bit so the post-final increment never wraps to 0
    localparam logic [NUM_DISKS:0] LAST_MOVE = {1'b0, {NUM_DISKS{1'b1}}};
    localparam bit N_ODD = (NUM_DISKS % 2) == 1;

    state_t                     state, nxt;
    logic [NUM_DISKS:0]         m;
    logic [NUM_DISKS-1:0][1:0]  pegs;
    logic [1:0]                 dst_q;
    logic                       err_q;

    logic [DISK_W-1:0]          cur_disk;
    logic [1:0]                 cur_from, cur_to, peg0;
    logic                       dir_down;
    logic                       start_ok, start_bad, xfer;

    assign start_ok  = (state == IDLE) && start && ((dst_peg == 2'd1) || (dst_peg == 2'd2));
    assign start_bad = (state == IDLE) && start && !((dst_peg == 2'd1) || (dst_peg == 2'd2));
    // abort wins over a handshake landing in the same cycle
    assign xfer      = (state == PRESENT) && move_ready && !abort;

    // Disk 0 walks 0->2->1 when parity of N and destination agree, else 0->1->2
    assign dir_down  = (N_ODD == (dst_q == 2'd2));
    assign peg0      = pegs[0];

    // Disk to move is the number of trailing zeros of m (m is never 0 here)
    always_comb begin
        cur_disk = '0;
        for (int i = NUM_DISKS - 1; i >= 0; i--) begin
            if (m[i]) cur_disk = DISK_W'(i);
        end
    end

    // Current peg of the selected disk
    always_comb begin
        cur_from = pegs[0];
        for (int i = 0; i < NUM_DISKS; i++) begin
            if (cur_disk == DISK_W'(i)) cur_from = pegs[i];
        end
    end

    // Target peg: cyclic step for disk 0, the remaining free peg otherwise
    always_comb begin
        cur_to = 2'd0;
        if (cur_disk == '0) begin
            if (dir_down) cur_to = (cur_from == 2'd0) ? 2'd2 : cur_from - 2'd1;
            else          cur_to = (cur_from == 2'd2) ? 2'd0 : cur_from + 2'd1;
        end else begin
            // pegs are distinct here, so 3 - a - b names the third peg
            cur_to = 2'd3 - peg0 - cur_from;
        end
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nxt;
    end

    // Next-state logic
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (start_ok) nxt = PRESENT;
            PRESENT: begin
                if (abort)                       nxt = IDLE;
                else if (xfer && m == LAST_MOVE) nxt = FINISH;
            end
            FINISH:  nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Solve context: destination, move counter, per-disk peg array, err pulse
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dst_q <= 2'd0;
            m     <= '0;
            pegs  <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= start_bad;
            if (start_ok) begin
                dst_q <= dst_peg;
                m     <= {{NUM_DISKS{1'b0}}, 1'b1};
                pegs  <= '0;
            end else if (xfer) begin
                m <= m + 1'b1;
                for (int i = 0; i < NUM_DISKS; i++) begin
                    if (cur_disk == DISK_W'(i)) pegs[i] <= cur_to;
                end
            end
        end
    end

    // Outputs decode from state so reset clears them without a clock edge
    always_comb begin
        move_valid = 1'b0;
        from_peg   = 2'd0;
        to_peg     = 2'd0;
        disk       = '0;
        move_idx   = '0;
        busy       = (state != IDLE);
        done       = (state == FINISH) && !abort;
        err        = err_q;
        if (state == PRESENT) begin
            move_valid = 1'b1;
            from_peg   = cur_from;
            to_peg     = cur_to;
            disk       = cur_disk;
            move_idx   = m[NUM_DISKS-1:0];
        end
    end

endmodule

// File: tb/tb_hanoi_move_gen.sv
// tb_hanoi_move_gen: directed checks of the move stream for N=1,2,3,4
// instances sharing one stimulus, against hand-derived move tables.
module tb_hanoi_move_gen;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       move_ready = 1'b0;
    logic [1:0] dst_peg = 2'd2;

    always #5 clock = ~clock;

    int nvec = 0;
    int nerr = 0;

    logic       v1, v2, v3, v4, b1, b2, b3, b4, d1, d2, d3, d4, e1, e2, e3, e4;
    logic [1:0] f1, f2, f3, f4, t1, t2, t3, t4;
    logic [3:0] k1, k2, k3, k4;
    logic [0:0] i1;
    logic [1:0] i2;
    logic [2:0] i3;
    logic [3:0] i4;

    hanoi_move_gen #(.NUM_DISKS(1), .DISK_W(4)) u1 (.clock(clock), .reset(reset), .start(start),
        .dst_peg(dst_peg), .abort(abort), .move_ready(move_ready), .move_valid(v1), .from_peg(f1),
        .to_peg(t1), .disk(k1), .move_idx(i1), .busy(b1), .done(d1), .err(e1));
    hanoi_move_gen #(.NUM_DISKS(2), .DISK_W(4)) u2 (.clock(clock), .reset(reset), .start(start),
        .dst_peg(dst_peg), .abort(abort), .move_ready(move_ready), .move_valid(v2), .from_peg(f2),
        .to_peg(t2), .disk(k2), .move_idx(i2), .busy(b2), .done(d2), .err(e2));
    hanoi_move_gen #(.NUM_DISKS(3), .DISK_W(4)) u3 (.clock(clock), .reset(reset), .start(start),
        .dst_peg(dst_peg), .abort(abort), .move_ready(move_ready), .move_valid(v3), .from_peg(f3),
        .to_peg(t3), .disk(k3), .move_idx(i3), .busy(b3), .done(d3), .err(e3));
    hanoi_move_gen #(.NUM_DISKS(4), .DISK_W(4)) u4 (.clock(clock), .reset(reset), .start(start),
        .dst_peg(dst_peg), .abort(abort), .move_ready(move_ready), .move_valid(v4), .from_peg(f4),
        .to_peg(t4), .disk(k4), .move_idx(i4), .busy(b4), .done(d4), .err(e4));

    // move word {from, to, disk}
    function automatic logic [7:0] mv(input int f, input int t, input int d);
        return {f[1:0], t[1:0], d[3:0]};
    endfunction

    // observation word {valid, busy, done, move, idx}
    function automatic logic [31:0] pk(input logic v, input logic b, input logic d,
                                       input logic [7:0] w, input int idx);
        return {13'd0, v, b, d, w, idx[7:0]};
    endfunction

    // expected observation at step i of an L-move run with ready held high
    function automatic logic [31:0] ex(input int i, input int l, input logic [7:0] w);
        if (i < l)  return pk(1'b1, 1'b1, 1'b0, w, i + 1);
        if (i == l) return pk(1'b0, 1'b1, 1'b1, 8'h00, 0);
        return pk(1'b0, 1'b0, 1'b0, 8'h00, 0);
    endfunction

    logic [31:0] o1, o2, o3, o4;
    assign o1 = pk(v1, b1, d1, {f1, t1, k1}, int'(i1));
    assign o2 = pk(v2, b2, d2, {f2, t2, k2}, int'(i2));
    assign o3 = pk(v3, b3, d3, {f3, t3, k3}, int'(i3));
    assign o4 = pk(v4, b4, d4, {f4, t4, k4}, int'(i4));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic clear_all();
        @(negedge clock); abort = 1'b1;
        @(negedge clock); abort = 1'b0;
    endtask

    logic [7:0] s3a [7];
    logic [7:0] s3b [7];
    logic [7:0] s2a [3];
    logic [7:0] s2b [3];
    logic [7:0] s4a [15];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] sav;
        bit          stall, seen;
        int          cnt, r;

        s3a = '{mv(0,2,0), mv(0,1,1), mv(2,1,0), mv(0,2,2), mv(1,0,0), mv(1,2,1), mv(0,2,0)};
        s3b = '{mv(0,1,0), mv(0,2,1), mv(1,2,0), mv(0,1,2), mv(2,0,0), mv(2,1,1), mv(0,1,0)};
        s2a = '{mv(0,1,0), mv(0,2,1), mv(1,2,0)};
        s2b = '{mv(0,2,0), mv(0,1,1), mv(2,1,0)};
        s4a = '{mv(0,1,0), mv(0,2,1), mv(1,2,0), mv(0,1,2), mv(2,0,0), mv(2,1,1), mv(0,1,0),
                mv(0,2,3), mv(1,2,0), mv(1,0,1), mv(2,0,0), mv(1,2,2), mv(0,1,0), mv(0,2,1),
                mv(1,2,0)};

        // reset state
        #2;
        chk("rst_o3", o3, 32'h0);
        chk("rst_err", {30'd0, e3, e4}, 32'h0);
        @(negedge clock); reset = 1'b0;

        // A: dst 2, ready high; a start during busy must not disturb anything
        @(negedge clock); start = 1'b1; dst_peg = 2'd2; move_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            @(negedge clock);
            chk($sformatf("a1_%0d", i), o1, ex(i, 1, mv(0,2,0)));
            chk($sformatf("a2_%0d", i), o2, ex(i, 3, (i < 3) ? s2a[i] : 8'h00));
            chk($sformatf("a3_%0d", i), o3, ex(i, 7, (i < 7) ? s3a[i] : 8'h00));
            chk($sformatf("a4_%0d", i), o4, ex(i, 15, (i < 15) ? s4a[i] : 8'h00));
            start   = (i == 1);
            dst_peg = (i == 1) ? 2'd1 : 2'd2;
        end

        // B: dst 1
        @(negedge clock); start = 1'b1; dst_peg = 2'd1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clock);
            chk($sformatf("b1_%0d", i), o1, ex(i, 1, mv(0,1,0)));
            chk($sformatf("b2_%0d", i), o2, ex(i, 3, (i < 3) ? s2b[i] : 8'h00));
            chk($sformatf("b3_%0d", i), o3, ex(i, 7, (i < 7) ? s3b[i] : 8'h00));
            start = 1'b0;
        end
        clear_all();

        // C: random backpressure on the N=3 stream
        @(negedge clock); start = 1'b1; dst_peg = 2'd2; move_ready = 1'b0;
        @(negedge clock); start = 1'b0;
        cnt = 0; stall = 1'b0; seen = 1'b0;
        for (int c = 0; c < 300 && !seen; c++) begin
            if (stall) chk($sformatf("c_hold%0d", cnt), o3, sav);
            if (v3) chk($sformatf("c_mv%0d", cnt), o3,
                        pk(1'b1, 1'b1, 1'b0, (cnt < 7) ? s3a[cnt] : 8'hff, cnt + 1));
            if (d3) seen = 1'b1;
            r = int'($urandom_range(0, 1));
            move_ready = (r != 0);
            stall = v3 && (r == 0);
            if (v3 && r != 0) cnt++;
            sav = o3;
            @(negedge clock);
        end
        chk("c_count", cnt, 7);
        chk("c_done", 32'(seen), 32'd1);
        clear_all();

        // D: N=4 abort while move 5 is presented and accepted
        move_ready = 1'b1;
        @(negedge clock); start = 1'b1; dst_peg = 2'd2;
        @(negedge clock); start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("d_mv%0d", i), o4, ex(i, 15, s4a[i]));
            if (i < 4) @(negedge clock);
        end
        abort = 1'b1;
        @(negedge clock); abort = 1'b0;
        chk("d_abort", o4, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk($sformatf("d_nodone%0d", i), o4, 32'h0);
        end
        start = 1'b1;
        @(negedge clock); start = 1'b0;
        chk("d_restart", o4, pk(1'b1, 1'b1, 1'b0, s4a[0], 1));
        clear_all();

        // E: illegal destinations
        @(negedge clock); start = 1'b1; dst_peg = 2'd0;
        @(negedge clock); start = 1'b0;
        chk("e_err0", {30'd0, e3, b3}, 32'h2);
        @(negedge clock);
        chk("e_err0_end", {30'd0, e3, b3}, 32'h0);
        start = 1'b1; dst_peg = 2'd3;
        @(negedge clock); start = 1'b0;
        chk("e_err3", {30'd0, e3, b3}, 32'h2);
        chk("e_idle", o3, 32'h0);

        // F: async reset mid-stall
        @(negedge clock); start = 1'b1; dst_peg = 2'd2; move_ready = 1'b0;
        @(negedge clock); start = 1'b0;
        @(negedge clock);
        chk("f_stalled", o3, pk(1'b1, 1'b1, 1'b0, s3a[0], 1));
        #2 reset = 1'b1;
        #1;
        chk("f_async3", o3, 32'h0);
        chk("f_async4", o4, 32'h0);
        @(negedge clock); reset = 1'b0; move_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk($sformatf("f_quiet%0d", i), o3, 32'h0);
        end
        start = 1'b1;
        @(negedge clock); start = 1'b0;
        chk("f_restart", o3, pk(1'b1, 1'b1, 1'b0, s3a[0], 1));
        clear_all();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/hanoi_move_gen.md
HANOI_MOVE_GEN -- requirements
Module: hanoi_move_gen

Interface
REQ-001 SHALL have parameter NUM_DISKS, default 3, the number of disks; legal range 1..15.
REQ-002 SHALL have parameter DISK_W, default 4, the width of the disk index; SHALL be ≥ ceil(log2(NUM_DISKS)), minimum 1.
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: request to begin a full solve.
REQ-006 SHALL have port dst_peg, input, 2 bits: destination peg (1 or 2), sampled with start.
REQ-007 SHALL have port abort, input, 1 bit: synchronous cancel of a running solve.
REQ-008 SHALL have port move_ready, input, 1 bit: downstream accepts the current move.
REQ-009 SHALL have port move_valid, output, 1 bit: a move is presented.
REQ-010 SHALL have port from_peg, output, 2 bits: source peg of the move (0..2).
REQ-011 SHALL have port to_peg, output, 2 bits: target peg of the move (0..2).
REQ-012 SHALL have port disk, output, DISK_W bits: disk moved (0 = smallest).
REQ-013 SHALL have port move_idx, output, NUM_DISKS bits: 1-based move number.
REQ-014 SHALL have ports busy, done and err, outputs, 1 bit each: status and one-cycle event pulses.

Function
REQ-015 SHALL implement FSM states IDLE, PRESENT, FINISH; reset state IDLE.
REQ-016 In IDLE, start=1 with dst_peg in {1,2} SHALL latch dst_peg, clear the per-disk peg array (all disks on peg 0), set move counter m=1, and enter PRESENT next cycle; the first move_valid=1 appears one cycle after start.
REQ-017 In IDLE, start=1 with dst_peg in {0,3} SHALL stay IDLE and pulse err for one cycle.
REQ-018 In PRESENT, the outputs SHALL be: disk = number of trailing zeros of m; from_peg = the current peg of that disk.
REQ-019 to_peg for disk 0 SHALL step cyclically 0→2→1→0 when (NUM_DISKS odd XNOR dst_peg==2), and 0→1→2→0 otherwise.
REQ-020 For disk > 0, to_peg SHALL be the peg holding neither disk 0 nor that disk.
REQ-021 For N=3 and dst 2, the move sequence SHALL be 0→2, 0→1, 2→1, 0→2, 1→0, 1→2, 0→2.
REQ-022 Handshake: move_valid, from_peg, to_peg, disk and move_idx SHALL hold stable while move_valid=1 and move_ready=0; a move transfers only on a cycle with move_valid=1 and move_ready=1.
REQ-023 On transfer, the peg array entry for that disk SHALL update to to_peg and m SHALL increment; the next move SHALL be presented the following cycle with no bubble.
REQ-024 When the transfer of move m = 2^NUM_DISKS−1 occurs, the FSM SHALL enter FINISH; FINISH SHALL pulse done for one cycle, then return to IDLE.
REQ-025 busy SHALL be 1 in PRESENT and FINISH, and 0 in IDLE.
REQ-026 start SHALL be ignored while busy=1.
REQ-027 abort=1 in PRESENT or FINISH SHALL return the FSM to IDLE next cycle with move_valid=0 and no done pulse; abort SHALL take priority over a simultaneous transfer.
REQ-028 m SHALL never wrap: the counter width is NUM_DISKS+1 internally, and move_idx SHALL show m[NUM_DISKS-1:0] with move_idx = 2^NUM_DISKS−1 on the last move.
REQ-029 With NUM_DISKS=1, exactly one move (0→dst) SHALL be produced, followed by done.
REQ-030 Outside PRESENT, from_peg, to_peg, disk and move_idx SHALL read 0.

Reset
REQ-031 reset=1 SHALL asynchronously force IDLE, with move_valid, busy, done, err, from_peg, to_peg, disk and move_idx all 0, and the peg array at 0.
REQ-032 Reset asserted mid-solve SHALL discard the solve; after release, no move SHALL appear until a new start.

Verification
REQ-033 N=3, dst=2, move_ready tied to 1, start pulse → seven moves on consecutive cycles with sequence per REQ-021, disks 0,1,0,2,0,1,0, move_idx 1..7, then done=1 for one cycle, busy=0.
REQ-034 N=2, dst=2 → moves 0→1, 0→2, 1→2; with dst=1 → 0→2, 0→1, 2→1.
REQ-035 N=3, move_ready toggled randomly → identical sequence; outputs stable across every stalled cycle; the transfer count equals 7.
REQ-036 N=4, abort after move 5 → move_valid=0 the next cycle, no done; a new start restarts at move_idx=1 with from_peg=0.
REQ-037 start with dst_peg=0 → err pulse, busy stays 0; start during busy → no effect on the sequence.
REQ-038 reset asserted mid-solve while move_valid=1 and move_ready=0 → all outputs 0 immediately, without waiting for a clock edge.
